// File: rtl/host_reg_slave.sv
// host_reg_slave: host-facing register slave for the router.
// Eight-register window with CTRL/PORT_EN/STATUS/INT_STAT/INT_MASK/DROP_CNT/SCRATCH,
// a one-cycle-latency tristate read path and a registered interrupt output.
module host_reg_slave #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [15:0] UNMAPPED_RD = 16'hDEAD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_n,
    input  logic [15:0] address,
    inout  wire  [15:0] data,
    input  logic        status_busy,
    input  logic        drop_pulse,
    input  logic        err_pulse,
    output logic [7:0]  ctrl,
    output logic [15:0] port_en,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PORT_EN  = 3'd1;
    localparam logic [2:0] OFF_STATUS   = 3'd2;
    localparam logic [2:0] OFF_INT_STAT = 3'd3;
    localparam logic [2:0] OFF_INT_MASK = 3'd4;
    localparam logic [2:0] OFF_DROP_CNT = 3'd5;
    localparam logic [2:0] OFF_SCRATCH  = 3'd6;

    logic [7:0]  ctrl_q,      ctrl_next;
    logic [15:0] port_en_q,   port_en_next;
    logic [1:0]  int_stat_q,  int_stat_next;
    logic [1:0]  int_mask_q,  int_mask_next;
    logic [15:0] drop_cnt_q,  drop_cnt_next;
    logic [15:0] scratch_q,   scratch_next;
    logic        irq_q;
    logic        rd_valid_q;
    logic        rd_in_win_q;
    logic [2:0]  rd_off_q;

    logic        in_window;
    logic [2:0]  offset;
    logic        wr_hit;
    logic [15:0] drop_base;
    logic [15:0] rd_data;
    logic        data_oe;

    // The window is eight words aligned on address[15:3]; offset is the distance from the base.
    assign in_window = (address[15:3] == BASE_ADDR[15:3]);
    assign offset    = address[2:0] - BASE_ADDR[2:0];
    assign wr_hit    = ~wr_n & in_window;

    // Next register state: host write first, then event pulses, so a set beats a W1C clear
    // and a counter clear coinciding with a drop leaves a count of one.
    always_comb begin
        ctrl_next     = ctrl_q;
        port_en_next  = port_en_q;
        int_stat_next = int_stat_q;
        int_mask_next = int_mask_q;
        scratch_next  = scratch_q;
        drop_base     = drop_cnt_q;
        if (wr_hit) begin
            case (offset)
                OFF_CTRL:     ctrl_next     = data[7:0];
                OFF_PORT_EN:  port_en_next  = data;
                OFF_INT_STAT: int_stat_next = int_stat_q & ~data[1:0];
                OFF_INT_MASK: int_mask_next = data[1:0];
                OFF_DROP_CNT: drop_base     = 16'h0000;
                OFF_SCRATCH:  scratch_next  = data;
                default:      ;
            endcase
        end
        drop_cnt_next = drop_base;
        if (drop_pulse && (drop_base != 16'hFFFF)) begin
            drop_cnt_next = drop_base + 16'h0001;
        end
        int_stat_next = int_stat_next | {err_pulse, drop_pulse};
    end

    // Register file and interrupt; irq is computed from the post-update status and mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= 8'h00;
            port_en_q  <= 16'hFFFF;
            int_stat_q <= 2'b00;
            int_mask_q <= 2'b00;
            drop_cnt_q <= 16'h0000;
            scratch_q  <= 16'h0000;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_next;
            port_en_q  <= port_en_next;
            int_stat_q <= int_stat_next;
            int_mask_q <= int_mask_next;
            drop_cnt_q <= drop_cnt_next;
            scratch_q  <= scratch_next;
            irq_q      <= |(int_stat_next & int_mask_next);
        end
    end

    // Read capture: every read-cycle edge latches the decoded address; a write edge cancels it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q  <= 1'b0;
            rd_in_win_q <= 1'b0;
            rd_off_q    <= 3'd0;
        end else begin
            rd_valid_q  <= wr_n;
            rd_in_win_q <= in_window;
            rd_off_q    <= offset;
        end
    end

    // Read mux over the registers as they stand after the sampling edge.
    always_comb begin
        rd_data = UNMAPPED_RD;
        if (rd_in_win_q) begin
            case (rd_off_q)
                OFF_CTRL:     rd_data = {8'h00, ctrl_q};
                OFF_PORT_EN:  rd_data = port_en_q;
                OFF_STATUS:   rd_data = {15'h0000, status_busy};
                OFF_INT_STAT: rd_data = {14'h0000, int_stat_q};
                OFF_INT_MASK: rd_data = {14'h0000, int_mask_q};
                OFF_DROP_CNT: rd_data = drop_cnt_q;
                OFF_SCRATCH:  rd_data = scratch_q;
                default:      rd_data = UNMAPPED_RD;
            endcase
        end
    end

    // The enable follows wr_n combinationally so the bus is free the moment a write starts.
    assign data_oe = rd_valid_q & wr_n;
    assign data    = data_oe ? rd_data : 16'hzzzz;

    assign ctrl    = ctrl_q;
    assign port_en = port_en_q;
    assign irq     = irq_q;

endmodule
